threshold_ctrl: RTL and testbench
=================================

# threshold_ctrl

Run-time configuration controller for the colour-threshold mask stage. It turns three debounced push-button levels into an edited channel select and lower/upper bound set, held in shadow registers. The shadow set is committed to the threshold datapath only at frame boundaries, so a mask never tears mid-frame. It also counts masked pixels per frame and reports the total as mask coverage for the centroid/display logic downstream.

## Interface
Parameters:
- COUNT_W, default 17: width of the masked-pixel counter; 17 covers 320x240.

Ports:
- clk_in  input  1  pixel clock
- rst_n_in  input  1  asynchronous, active-low reset
- btn_mode_in  input  1  debounced, synchronized level; rising edge advances the edit mode
- btn_up_in  input  1  debounced, synchronized level; rising edge increments the field being edited
- btn_down_in  input  1  debounced, synchronized level; rising edge decrements the field being edited
- frame_start_in  input  1  one-cycle pulse at the first pixel of each frame
- pixel_valid_in  input  1  qualifies mask_in
- mask_in  input  1  mask bit from the threshold stage
- sel_out  output  3  active channel select
- lower_bound_out  output  4  active lower bound
- upper_bound_out  output  4  active upper bound
- mode_out  output  2  current edit mode (0 SEL, 1 LOWER, 2 UPPER)
- pending_out  output  1  shadow set differs from active set
- mask_count_out  output  COUNT_W  masked-pixel total of the last complete frame
- count_valid_out  output  1  one-cycle pulse when mask_count_out updates

## Operation
- Edge detect on each button: edge = level & ~prev. The prev registers reset to 1, so a button held through reset does not fire.
- Mode FSM:
  - Cycle: SEL -> LOWER -> UPPER -> SEL on each btn_mode edge.
  - Encoding 3 is unreachable; if entered, it returns to SEL on the next clock.
- Field edits, applied to the field of the mode *before* any same-cycle mode change:
  - SEL: steps through the legal order 0,1,2,4,5,6 and wraps both directions (6 up -> 0, 0 down -> 6). Codes 3 and 7 are never produced.
  - LOWER/UPPER: 4-bit saturating, clamped at 0 and 15, with no wrap. No ordering is enforced between lower and upper.
  - up and down edges in the same cycle: no change.
- Commit: in a frame_start_in cycle, the active registers load the shadow registers as they stood at the start of that cycle. An edit edge in the same cycle lands in shadow only and commits at the next frame.
- pending_out = (shadow != active), registered.
- Masked-pixel counter:
  - Increments when pixel_valid_in & mask_in.
  - Saturates at 2^COUNT_W-1.
  - On a frame_start_in cycle:
    - mask_count_out <= counter.
    - counter <= (pixel_valid_in & mask_in), because that pixel belongs to the new frame.
    - count_valid_out is asserted on the next cycle.
- Reset values:
  - sel_out 0 (green), lower_bound_out 0, upper_bound_out 15; shadow identical.
  - mode_out SEL, pending_out 0.
  - mask_count_out 0, count_valid_out 0, counter 0.

## Timing
- Button rising edge sampled at cycle N updates shadow and mode_out at the clock edge ending cycle N; pending_out updates one cycle later.
- frame_start_in high in cycle F:
  - Active outputs and mask_count_out change at the clock edge ending F.
  - count_valid_out is high during F+1.
- Back-to-back frame_start_in pulses are legal. Each pulse commits, reports and restarts the counter.
- Reset assertion mid-frame immediately forces all reset values. Counting resumes on release, but mask_count_out reports only after the next frame_start_in.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package threshold_pkg:
  - mode enum (MODE_SEL, MODE_LOWER, MODE_UPPER).
  - SEL_GREEN…SEL_CB channel-code constants.
  - Pure functions sel_next/sel_prev implementing the legal-order wrap.
  - Reset constants LOWER_RST = 0, UPPER_RST = 15.
- Sub-module: edge_rise, a single-bit rising-edge detector with parameterized reset value for prev; instantiate three times.

## Test plan
- Reset with btn_up_in held high, then release reset: no edit. Outputs read sel 0, lower 0, upper 15, mode 0, pending 0.
- Mode SEL, 7 up edges: shadow sel goes 1,2,4,5,6,0,1. Then one down edge gives 0 and one more down edge gives 6. Active sel stays 0 until frame_start_in, then becomes 6 and pending_out clears.
- Mode LOWER:
  - 3 down edges: lower stays 0.
  - 20 up edges: saturates at 15.
  - Up and down edges in the same cycle: no change.
- Mode edge plus up edge in the same cycle while in SEL: sel advances 0 -> 1 and mode_out becomes LOWER.
- Edit edge coincident with frame_start_in: active keeps the old value, pending_out = 1, and the value commits at the next frame_start_in.
- Frame of 100 valid pixels with 37 masked, and a masked valid pixel in the next frame_start_in cycle: mask_count_out = 37, count_valid_out pulses once, and the internal counter restarts at 1. With COUNT_W = 4 and 20 masked pixels, the count saturates at 15.

Source files
------------

// File: rtl/threshold_pkg.sv
// Shared types, channel codes and step helpers for the colour-threshold
// configuration controller.
package threshold_pkg;

  typedef enum logic [1:0] {
    MODE_SEL   = 2'd0,
    MODE_LOWER = 2'd1,
    MODE_UPPER = 2'd2
  } mode_t;

  localparam logic [2:0] SEL_GREEN = 3'd0;
  localparam logic [2:0] SEL_RED   = 3'd1;
  localparam logic [2:0] SEL_BLUE  = 3'd2;
  localparam logic [2:0] SEL_Y     = 3'd4;
  localparam logic [2:0] SEL_CR    = 3'd5;
  localparam logic [2:0] SEL_CB    = 3'd6;

  localparam logic [3:0] LOWER_RST = 4'd0;
  localparam logic [3:0] UPPER_RST = 4'd15;

  // Legal channel order is 0,1,2,4,5,6; codes 3 and 7 fall back to green.
  function automatic logic [2:0] sel_next(input logic [2:0] s);
    case (s)
      SEL_GREEN: sel_next = SEL_RED;
      SEL_RED:   sel_next = SEL_BLUE;
      SEL_BLUE:  sel_next = SEL_Y;
      SEL_Y:     sel_next = SEL_CR;
      SEL_CR:    sel_next = SEL_CB;
      default:   sel_next = SEL_GREEN;
    endcase
  endfunction

  function automatic logic [2:0] sel_prev(input logic [2:0] s);
    case (s)
      SEL_GREEN: sel_prev = SEL_CB;
      SEL_RED:   sel_prev = SEL_GREEN;
      SEL_BLUE:  sel_prev = SEL_RED;
      SEL_Y:     sel_prev = SEL_BLUE;
      SEL_CR:    sel_prev = SEL_Y;
      SEL_CB:    sel_prev = SEL_CR;
      default:   sel_prev = SEL_GREEN;
    endcase
  endfunction

  // 4-bit bound step, clamped at 0 and 15; up and down together cancel.
  function automatic logic [3:0] bound_step(input logic [3:0] b, input logic up,
                                            input logic dn);
    bound_step = b;
    if (up && !dn && b != 4'hf) bound_step = b + 4'd1;
    else if (dn && !up && b != 4'h0) bound_step = b - 4'd1;
  endfunction

endpackage

// File: rtl/threshold_ctrl_edge_rise.sv
// Single-bit rising-edge detector; prev reset value is a parameter so a
// level held high through reset does not produce an edge on release.
module edge_rise #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= RST_VAL;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/threshold_ctrl.sv
// Button-driven editor for the threshold channel/bounds with frame-aligned
// commit, plus a per-frame masked-pixel coverage counter.
module threshold_ctrl
  import threshold_pkg::*;
#(
  parameter int COUNT_W = 17
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               btn_mode_in,
  input  logic               btn_up_in,
  input  logic               btn_down_in,
  input  logic               frame_start_in,
  input  logic               pixel_valid_in,
  input  logic               mask_in,
  output logic [2:0]         sel_out,
  output logic [3:0]         lower_bound_out,
  output logic [3:0]         upper_bound_out,
  output logic [1:0]         mode_out,
  output logic               pending_out,
  output logic [COUNT_W-1:0] mask_count_out,
  output logic               count_valid_out
);

  logic mode_rise, up_rise, dn_rise;

  edge_rise #(.RST_VAL(1'b1)) u_mode_edge (
    .clk(clk_in), .rst_n(rst_n_in), .level(btn_mode_in), .rise(mode_rise));
  edge_rise #(.RST_VAL(1'b1)) u_up_edge (
    .clk(clk_in), .rst_n(rst_n_in), .level(btn_up_in), .rise(up_rise));
  edge_rise #(.RST_VAL(1'b1)) u_dn_edge (
    .clk(clk_in), .rst_n(rst_n_in), .level(btn_down_in), .rise(dn_rise));

  mode_t      mode_q;
  logic [2:0] sh_sel;
  logic [3:0] sh_lower, sh_upper;

  assign mode_out = mode_q;

  // Edits act on the field selected by the mode held before this edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mode_q   <= MODE_SEL;
      sh_sel   <= SEL_GREEN;
      sh_lower <= LOWER_RST;
      sh_upper <= UPPER_RST;
    end else begin
      case (mode_q)
        MODE_SEL: begin
          if (mode_rise) mode_q <= MODE_LOWER;
          if (up_rise && !dn_rise)      sh_sel <= sel_next(sh_sel);
          else if (dn_rise && !up_rise) sh_sel <= sel_prev(sh_sel);
        end
        MODE_LOWER: begin
          if (mode_rise) mode_q <= MODE_UPPER;
          sh_lower <= bound_step(sh_lower, up_rise, dn_rise);
        end
        MODE_UPPER: begin
          if (mode_rise) mode_q <= MODE_SEL;
          sh_upper <= bound_step(sh_upper, up_rise, dn_rise);
        end
        default: mode_q <= MODE_SEL;
      endcase
    end
  end

  // Active set only moves on frame boundaries so a mask never tears.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sel_out         <= SEL_GREEN;
      lower_bound_out <= LOWER_RST;
      upper_bound_out <= UPPER_RST;
      pending_out     <= 1'b0;
    end else begin
      if (frame_start_in) begin
        sel_out         <= sh_sel;
        lower_bound_out <= sh_lower;
        upper_bound_out <= sh_upper;
      end
      pending_out <= (sh_sel != sel_out) || (sh_lower != lower_bound_out) ||
                     (sh_upper != upper_bound_out);
    end
  end

  logic               hit;
  logic [COUNT_W-1:0] cnt;

  assign hit = pixel_valid_in & mask_in;

  // The pixel seen with frame_start belongs to the new frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt             <= '0;
      mask_count_out  <= '0;
      count_valid_out <= 1'b0;
    end else if (frame_start_in) begin
      mask_count_out  <= cnt;
      cnt             <= {{(COUNT_W-1){1'b0}}, hit};
      count_valid_out <= 1'b1;
    end else begin
      count_valid_out <= 1'b0;
      if (hit && cnt != {COUNT_W{1'b1}}) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_threshold_ctrl.sv
// Directed bench for threshold_ctrl; coverage counts are scoreboarded and
// checked whenever count_valid_out pulses.
module tb_threshold_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_mode, btn_up, btn_down, frame_start, pixel_valid, mask;
  logic [2:0]  sel;
  logic [3:0]  lower, upper;
  logic [1:0]  mode;
  logic        pending, count_valid;
  logic [16:0] mask_count;
  logic [2:0]  s_sel;
  logic [3:0]  s_lower, s_upper;
  logic [1:0]  s_mode;
  logic        s_pending, s_count_valid;
  logic [3:0]  s_mask_count;

  int tests = 0;
  int fails = 0;
  int model_cnt = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  threshold_ctrl u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .btn_mode_in(btn_mode), .btn_up_in(btn_up),
    .btn_down_in(btn_down), .frame_start_in(frame_start),
    .pixel_valid_in(pixel_valid), .mask_in(mask), .sel_out(sel),
    .lower_bound_out(lower), .upper_bound_out(upper), .mode_out(mode),
    .pending_out(pending), .mask_count_out(mask_count),
    .count_valid_out(count_valid));

  threshold_ctrl #(.COUNT_W(4)) u_sat (
    .clk_in(clk), .rst_n_in(rst_n), .btn_mode_in(btn_mode), .btn_up_in(btn_up),
    .btn_down_in(btn_down), .frame_start_in(frame_start),
    .pixel_valid_in(pixel_valid), .mask_in(mask), .sel_out(s_sel),
    .lower_bound_out(s_lower), .upper_bound_out(s_upper), .mode_out(s_mode),
    .pending_out(s_pending), .mask_count_out(s_mask_count),
    .count_valid_out(s_count_valid));

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    btn_mode = m; btn_up = u; btn_down = d;
    tick();
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    tick();
  endtask

  task automatic pix(input logic v, input logic m);
    pixel_valid = v; mask = m;
    if (v && m) model_cnt++;
    tick();
    pixel_valid = 1'b0; mask = 1'b0;
  endtask

  task automatic frame(input logic h);
    exp_q.push_back(model_cnt);
    model_cnt = h ? 1 : 0;
    frame_start = 1'b1; pixel_valid = h; mask = h;
    tick();
    frame_start = 1'b0; pixel_valid = 1'b0; mask = 1'b0;
  endtask

  // Scoreboard: each count_valid pulse consumes one expected frame total.
  always @(posedge clk) begin
    #1;
    if (count_valid) begin
      if (exp_q.size() == 0) chk("cv_unexpected", 1, 0);
      else chk("mask_count", int'(mask_count), exp_q.pop_front());
    end
  end

  logic [2:0] up_order [6];

  initial begin
    up_order = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd0};
    rst_n = 1'b0; btn_mode = 1'b0; btn_up = 1'b1; btn_down = 1'b0;
    frame_start = 1'b0; pixel_valid = 1'b0; mask = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_sel", sel, 0);
    chk("rst_lower", lower, 0);
    chk("rst_upper", upper, 15);
    chk("rst_mode", mode, 0);
    chk("rst_pending", pending, 0);
    chk("rst_count", mask_count, 0);
    chk("rst_cv", count_valid, 0);
    btn_up = 1'b0;
    repeat (2) tick();
    chk("held_btn_pending", pending, 0);
    frame(1'b0);
    chk("held_btn_sel", sel, 0);

    // SEL legal order, one commit per step
    for (int i = 0; i < 6; i++) begin
      press(1'b0, 1'b1, 1'b0);
      chk("sel_pending", pending, 1);
      frame(1'b0);
      chk("sel_up_order", sel, up_order[i]);
    end
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    chk("sel_hold_active", sel, 0);
    chk("sel_wrap_pending", pending, 1);
    frame(1'b0);
    chk("sel_wrap_down", sel, 6);
    tick();
    chk("sel_pending_clear", pending, 0);

    // LOWER saturation
    press(1'b1, 1'b0, 1'b0);
    chk("mode_lower", mode, 1);
    repeat (3) press(1'b0, 1'b0, 1'b1);
    chk("lower_floor_pending", pending, 0);
    repeat (20) press(1'b0, 1'b1, 1'b0);
    frame(1'b0);
    chk("lower_ceiling", lower, 15);
    chk("lower_keeps_sel", sel, 6);
    press(1'b0, 1'b0, 1'b1);
    frame(1'b0);
    chk("lower_dec", lower, 14);
    press(1'b0, 1'b1, 1'b1);
    chk("updn_pending", pending, 0);
    frame(1'b0);
    chk("updn_nochange", lower, 14);

    // UPPER edit, then back to SEL
    press(1'b1, 1'b0, 1'b0);
    chk("mode_upper", mode, 2);
    press(1'b0, 1'b0, 1'b1);
    frame(1'b0);
    chk("upper_dec", upper, 14);
    chk("upper_keeps_lower", lower, 14);
    press(1'b1, 1'b0, 1'b0);
    chk("mode_sel_wrap", mode, 0);
    press(1'b0, 1'b1, 1'b0);
    frame(1'b0);
    chk("sel_6_to_0", sel, 0);

    // mode + up same cycle edits the pre-change field
    press(1'b1, 1'b1, 1'b0);
    chk("mode_up_mode", mode, 1);
    frame(1'b0);
    chk("mode_up_sel", sel, 1);
    chk("mode_up_lower", lower, 14);

    // edit coincident with frame_start lands in shadow only
    exp_q.push_back(model_cnt);
    model_cnt = 0;
    btn_up = 1'b1; frame_start = 1'b1;
    tick();
    btn_up = 1'b0; frame_start = 1'b0;
    chk("coinc_active_old", lower, 14);
    tick();
    chk("coinc_pending", pending, 1);
    frame(1'b0);
    chk("coinc_commit", lower, 15);
    tick();
    chk("coinc_pending_clear", pending, 0);

    // coverage: 100 valid pixels, 37 masked
    for (int i = 0; i < 100; i++) pix(1'b1, i < 37);
    pix(1'b0, 1'b1);
    frame(1'b1);
    chk("cov_cv_pulse", count_valid, 1);
    chk("cov_sat_count", s_mask_count, 15);
    tick();
    chk("cov_cv_once", count_valid, 0);
    repeat (3) tick();
    frame(1'b0);
    chk("cov_restart_sat", s_mask_count, 1);
    frame(1'b0);
    frame(1'b0);
    chk("b2b_count", mask_count, 0);

    // asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) pix(1'b1, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_lower", lower, 0);
    chk("arst_sel", sel, 0);
    chk("arst_count", mask_count, 0);
    chk("arst_pending", pending, 0);
    model_cnt = 0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b1);
    chk("arst_no_report", count_valid, 0);
    frame(1'b0);
    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
